// File: rtl/chimp_board_loader_if.sv
// Handshake with the chimp control FSM plus the board-RAM write port driven by the loader.
interface chimp_board_loader_if;
  logic       iStart;
  logic [4:0] iLevel;
  logic       oWrEn;
  logic [5:0] oWrAddr;
  logic [4:0] oWrData;
  logic       oBusy;
  logic       oDone;
  logic [4:0] oPlaced;

  modport master (output iStart, iLevel, input oWrEn, oWrAddr, oWrData, oBusy, oDone, oPlaced);
  modport slave  (input iStart, iLevel, output oWrEn, oWrAddr, oWrData, oBusy, oDone, oPlaced);
endinterface

// File: rtl/chimp_board_loader.sv
// Board-load sequencer for the chimp test: clears the tile RAM, then scatters tiles 1..L over
// distinct LFSR-chosen cells, falling back to a linear scan after too many rejected picks.
module chimp_board_loader #(
  parameter int          ROWS   = 5,
  parameter int          COLS   = 8,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          MAXTRY = 63
) (
  input logic                 clk,
  input logic                 iResetn,
  chimp_board_loader_if.slave bus
);
  localparam int            CELLS      = ROWS * COLS;
  localparam int            RW         = (MAXTRY < 2) ? 1 : $clog2(MAXTRY + 1);
  localparam logic [6:0]    CELLS_C    = 7'(CELLS);
  localparam logic [5:0]    LAST_CELL  = 6'(CELLS - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAXTRY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PICK  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [5:0]    ptr_r, ptr_nxt_s;
  logic [RW-1:0] retry_r, retry_nxt_s;
  logic [4:0]    lq_r, lq_nxt_s;
  logic [63:0]   occ_r, occ_nxt_s;
  logic [4:0]    placed_r, placed_nxt_s;
  logic [15:0]   lfsr_r;
  logic          wr_en_r, wr_en_nxt_s;
  logic [5:0]    wr_addr_r, wr_addr_nxt_s;
  logic [4:0]    wr_data_r, wr_data_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic [5:0]    cand_s;
  logic [4:0]    place_s;
  logic [4:0]    level_cap_s;

  // Fibonacci LFSR, taps 16,14,13,11 (shift toward bit 0, feedback into bit 15)
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  assign bus.oWrEn   = wr_en_r;
  assign bus.oWrAddr = wr_addr_r;
  assign bus.oWrData = wr_data_r;
  assign bus.oBusy   = busy_r;
  assign bus.oDone   = done_r;
  assign bus.oPlaced = placed_r;

  // State, bookkeeping and registered outputs; the LFSR free-runs in every state
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 6'd0;
      retry_r   <= '0;
      lq_r      <= 5'd0;
      occ_r     <= 64'd0;
      placed_r  <= 5'd0;
      lfsr_r    <= SEED;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 6'd0;
      wr_data_r <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      retry_r   <= retry_nxt_s;
      lq_r      <= lq_nxt_s;
      occ_r     <= occ_nxt_s;
      placed_r  <= placed_nxt_s;
      lfsr_r    <= lfsr_step(lfsr_r);
      wr_en_r   <= wr_en_nxt_s;
      wr_addr_r <= wr_addr_nxt_s;
      wr_data_r <= wr_data_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  // Next-state and next-output logic; writes are issued on the edge that leaves each step
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    retry_nxt_s   = retry_r;
    lq_nxt_s      = lq_r;
    occ_nxt_s     = occ_r;
    placed_nxt_s  = placed_r;
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    cand_s        = lfsr_r[5:0];
    place_s       = placed_r + 5'd1;
    level_cap_s   = ({2'b00, bus.iLevel} > CELLS_C) ? CELLS_C[4:0] : bus.iLevel;

    case (state_r)
      ST_IDLE: begin
        // Accepting a start already issues the clear of cell 0
        if (bus.iStart) begin
          state_nxt_s   = ST_CLEAR;
          lq_nxt_s      = level_cap_s;
          ptr_nxt_s     = 6'd1;
          retry_nxt_s   = '0;
          placed_nxt_s  = 5'd0;
          occ_nxt_s     = 64'd0;
          busy_nxt_s    = 1'b1;
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = 6'd0;
          wr_data_nxt_s = 5'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        wr_en_nxt_s       = 1'b1;
        wr_addr_nxt_s     = ptr_r;
        wr_data_nxt_s     = 5'd0;
        occ_nxt_s[ptr_r]  = 1'b0;
        if (ptr_r == LAST_CELL) begin
          ptr_nxt_s   = 6'd0;
          state_nxt_s = (lq_r == 5'd0) ? ST_DONE : ST_PICK;
        end else begin
          ptr_nxt_s = ptr_r + 6'd1;
        end
      end
      ST_PICK: begin
        if (({1'b0, cand_s} < CELLS_C) && !occ_r[cand_s]) begin
          wr_en_nxt_s       = 1'b1;
          wr_addr_nxt_s     = cand_s;
          wr_data_nxt_s     = place_s;
          occ_nxt_s[cand_s] = 1'b1;
          placed_nxt_s      = place_s;
          retry_nxt_s       = '0;
          state_nxt_s       = (place_s == lq_r) ? ST_DONE : ST_PICK;
        end else begin
          retry_nxt_s = retry_r + RW'(1);
          if (retry_r == RETRY_LAST) begin
            state_nxt_s = ST_SCAN;
            ptr_nxt_s   = 6'd0;
          end else begin
            state_nxt_s = ST_PICK;
          end
        end
      end
      ST_SCAN: begin
        // Terminates because lq never exceeds the number of cells
        if (!occ_r[ptr_r]) begin
          wr_en_nxt_s      = 1'b1;
          wr_addr_nxt_s    = ptr_r;
          wr_data_nxt_s    = place_s;
          occ_nxt_s[ptr_r] = 1'b1;
          placed_nxt_s     = place_s;
          retry_nxt_s      = '0;
          state_nxt_s      = (place_s == lq_r) ? ST_DONE : ST_PICK;
        end else begin
          ptr_nxt_s = ptr_r + 6'd1;
        end
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_chimp_board_loader.sv
// Self-checking bench: randomized loads on a 5x8 board and a 2x4 board (short retry limit),
// compared against a cycle-timed model of the load rules.
module tb_chimp_board_loader;
  localparam logic [15:0] SEED_L = 16'hACE1;
  localparam logic [15:0] SEED_S = 16'h1D2B;

  typedef struct {int addr; int data; int cyc;} wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_v;
  logic [4:0] level_v;
  bit sel;
  int edges;
  int checks = 0;
  int failures = 0;
  int n_scan = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int exp_done, obs_done, prof_err;
  logic m_en, m_busy, m_done;
  logic [5:0] m_addr;
  logic [4:0] m_data, m_placed;

  always #5 clk = ~clk;

  chimp_board_loader_if bus_l ();
  chimp_board_loader_if bus_s ();

  chimp_board_loader dut_l (.clk(clk), .iResetn(rst_n), .bus(bus_l.slave));
  chimp_board_loader #(.ROWS(2), .COLS(4), .SEED(SEED_S), .MAXTRY(3))
    dut_s (.clk(clk), .iResetn(rst_n), .bus(bus_s.slave));

  assign bus_l.iStart = start_v & ~sel;
  assign bus_l.iLevel = level_v;
  assign bus_s.iStart = start_v & sel;
  assign bus_s.iLevel = level_v;

  always_comb begin
    m_en     = sel ? bus_s.oWrEn   : bus_l.oWrEn;
    m_addr   = sel ? bus_s.oWrAddr : bus_l.oWrAddr;
    m_data   = sel ? bus_s.oWrData : bus_l.oWrData;
    m_busy   = sel ? bus_s.oBusy   : bus_l.oBusy;
    m_done   = sel ? bus_s.oDone   : bus_l.oDone;
    m_placed = sel ? bus_s.oPlaced : bus_l.oPlaced;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;
  end

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic int cells_now();
    return sel ? 8 : 40;
  endfunction

  function automatic int lq_of(input int lvl);
    return (lvl < cells_now()) ? lvl : cells_now();
  endfunction

  // Model: edge 0 accepts the start; a write decided at edge e is visible in cycle e+1.
  task automatic predict(input logic [15:0] l0, input int lvl);
    logic [15:0] l;
    bit occ[64];
    int e, tries, cells, maxtry, lq, f;
    bit got;
    l = l0; e = 0; tries = 0;
    cells = cells_now(); maxtry = sel ? 3 : 63; lq = lq_of(lvl);
    foreach (occ[i]) occ[i] = 1'b0;
    exp_q.delete();
    for (int c = 0; c < cells; c++) begin
      exp_q.push_back(wr_t'{c, 0, e + 1}); l = step(l); e++;
    end
    for (int t = 1; t <= lq; t++) begin
      got = 1'b0;
      while (!got) begin
        if (tries == maxtry) begin
          f = 0;
          while (occ[f]) f++;
          repeat (f) l = step(l);
          e += f;
          occ[f] = 1'b1; exp_q.push_back(wr_t'{f, t, e + 1});
          l = step(l); e++; tries = 0; got = 1'b1; n_scan++;
        end else begin
          if (int'(l[5:0]) < cells && !occ[l[5:0]]) begin
            occ[l[5:0]] = 1'b1; exp_q.push_back(wr_t'{int'(l[5:0]), t, e + 1});
            tries = 0; got = 1'b1;
          end else begin
            tries++;
          end
          l = step(l); e++;
        end
      end
    end
    exp_done = e + 1;
  endtask

  // Starts a load on the selected board and records writes, busy/done profile and done cycle
  task automatic capture(input int lvl, input bit poke);
    logic [15:0] l0;
    @(negedge clk);
    l0 = sel ? SEED_S : SEED_L;
    repeat (edges) l0 = step(l0);
    predict(l0, lvl);
    obs_q.delete(); obs_done = -1; prof_err = 0;
    level_v = 5'(lvl); start_v = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start_v = poke && (k == 4 || k == 19 || k == exp_done - 2);
      if (poke) level_v = 5'($urandom_range(0, 31));
      if (m_en) obs_q.push_back(wr_t'{int'(m_addr), int'(m_data), k});
      if (m_busy !== (k < exp_done)) prof_err++;
      if (m_done !== (k == exp_done)) prof_err++;
      if (m_done === 1'b1 && obs_done < 0) obs_done = k;
      if ((obs_done >= 0 && k > obs_done) || k > exp_done + 200) break;
    end
    start_v = 1'b0;
  endtask

  function automatic int seq_diff();
    int d = 0;
    if (obs_q.size() != exp_q.size()) d++;
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data ||
            obs_q[i].cyc != exp_q[i].cyc) d++;
      end
    end
    return d;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_l.oWrEn, bus_l.oWrAddr, bus_l.oWrData, bus_l.oBusy, bus_l.oDone, bus_l.oPlaced} !== 19'd0) begin
      failures++; $display("FAIL reset_large: got %0h want 0",
        {bus_l.oWrEn, bus_l.oWrAddr, bus_l.oWrData, bus_l.oBusy, bus_l.oDone, bus_l.oPlaced});
    end
    checks++;
    if ({bus_s.oWrEn, bus_s.oWrAddr, bus_s.oWrData, bus_s.oBusy, bus_s.oDone, bus_s.oPlaced} !== 19'd0) begin
      failures++; $display("FAIL reset_small: got %0h want 0",
        {bus_s.oWrEn, bus_s.oWrAddr, bus_s.oWrData, bus_s.oBusy, bus_s.oDone, bus_s.oPlaced});
    end
    rst_n = 1'b1;
    repeat ($urandom_range(2, 9)) @(negedge clk);
  endtask

  task automatic test_level4();
    int bad = 0;
    int seen_d[32];
    bit used_a[64];
    sel = 1'b0;
    capture(4, 1'b0);
    foreach (seen_d[i]) seen_d[i] = 0;
    foreach (used_a[i]) used_a[i] = 1'b0;
    foreach (obs_q[i]) begin
      if (i < 40) begin
        if (obs_q[i].addr != i || obs_q[i].data != 0) bad++;
      end else begin
        if (obs_q[i].data < 1 || obs_q[i].data > 4 || obs_q[i].addr > 39 || used_a[obs_q[i].addr]) bad++;
        else begin used_a[obs_q[i].addr] = 1'b1; seen_d[obs_q[i].data]++; end
      end
    end
    checks++;
    if (obs_q.size() !== 44) begin failures++; $display("FAIL l4_count: got %0d want 44", obs_q.size()); end
    checks++;
    if (bad !== 0 || seen_d[1] != 1 || seen_d[2] != 1 || seen_d[3] != 1 || seen_d[4] != 1) begin
      failures++; $display("FAIL l4_pattern: got %0d bad writes want 0", bad);
    end
    checks++;
    if (seq_diff() !== 0) begin failures++; $display("FAIL l4_model: got %0d diffs want 0", seq_diff()); end
    checks++;
    if (obs_done !== exp_done) begin failures++; $display("FAIL l4_done: got %0d want %0d", obs_done, exp_done); end
    checks++;
    if (prof_err !== 0) begin failures++; $display("FAIL l4_profile: got %0d errs want 0", prof_err); end
    checks++;
    if (m_placed !== 5'd4) begin failures++; $display("FAIL l4_placed: got %0d want 4", m_placed); end
  endtask

  task automatic test_level0();
    int bad = 0;
    sel = 1'b0;
    capture(0, 1'b0);
    foreach (obs_q[i]) if (obs_q[i].addr != i || obs_q[i].data != 0) bad++;
    checks++;
    if (obs_q.size() !== 40 || bad !== 0) begin
      failures++; $display("FAIL l0_clears: got %0d writes %0d bad want 40 0", obs_q.size(), bad);
    end
    checks++;
    if (obs_done !== 41) begin failures++; $display("FAIL l0_done: got %0d want 41", obs_done); end
    checks++;
    if (m_placed !== 5'd0) begin failures++; $display("FAIL l0_placed: got %0d want 0", m_placed); end
  endtask

  task automatic test_small_full();
    int bad;
    int seen_d[32];
    bit used_a[64];
    sel = 1'b1;
    for (int r = 0; r < 4; r++) begin
      capture(31, 1'b0);
      bad = 0;
      foreach (seen_d[i]) seen_d[i] = 0;
      foreach (used_a[i]) used_a[i] = 1'b0;
      foreach (obs_q[i]) begin
        if (i >= 8) begin
          if (obs_q[i].addr > 7 || used_a[obs_q[i].addr] || obs_q[i].data < 1 || obs_q[i].data > 8) bad++;
          else begin used_a[obs_q[i].addr] = 1'b1; seen_d[obs_q[i].data]++; end
        end
      end
      for (int d = 1; d <= 8; d++) if (seen_d[d] != 1) bad++;
      checks++;
      if (obs_q.size() !== 16 || bad !== 0) begin
        failures++; $display("FAIL full_small: got %0d writes %0d bad want 16 0", obs_q.size(), bad);
      end
      checks++;
      if (seq_diff() !== 0 || obs_done !== exp_done || prof_err !== 0) begin
        failures++; $display("FAIL full_model: got diffs=%0d done=%0d want 0 %0d", seq_diff(), obs_done, exp_done);
      end
      checks++;
      if (m_placed !== 5'd8) begin failures++; $display("FAIL full_placed: got %0d want 8", m_placed); end
    end
    $display("info: model scan fallbacks so far = %0d", n_scan);
  endtask

  task automatic test_busy_ignore();
    sel = 1'b0;
    capture(6, 1'b1);
    checks++;
    if (seq_diff() !== 0) begin failures++; $display("FAIL busy_seq: got %0d diffs want 0", seq_diff()); end
    checks++;
    if (obs_done !== exp_done || prof_err !== 0) begin
      failures++; $display("FAIL busy_done: got %0d (%0d errs) want %0d", obs_done, prof_err, exp_done);
    end
    checks++;
    if (m_placed !== 5'd6) begin failures++; $display("FAIL busy_placed: got %0d want 6", m_placed); end
  endtask

  task automatic test_random();
    int lvl;
    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom_range(0, 1));
      lvl = $urandom_range(0, 31);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      capture(lvl, 1'b0);
      checks++;
      if (seq_diff() !== 0) begin
        failures++; $display("FAIL rand_seq: got %0d diffs want 0 (sel %0d lvl %0d)", seq_diff(), sel, lvl);
      end
      checks++;
      if (obs_done !== exp_done || prof_err !== 0) begin
        failures++; $display("FAIL rand_done: got %0d (%0d errs) want %0d", obs_done, prof_err, exp_done);
      end
      checks++;
      if (m_placed !== 5'(lq_of(lvl))) begin
        failures++; $display("FAIL rand_placed: got %0d want %0d", m_placed, lq_of(lvl));
      end
    end
  endtask

  task automatic test_reset_midload();
    int wr_in_rst = 0;
    sel = 1'b0;
    @(negedge clk);
    level_v = 5'd10; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (44) @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %0b want 1", m_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_l.oWrEn, bus_l.oWrAddr, bus_l.oWrData, bus_l.oBusy, bus_l.oDone, bus_l.oPlaced} !== 19'd0) begin
      failures++; $display("FAIL mid_async: got %0h want 0",
        {bus_l.oWrEn, bus_l.oWrAddr, bus_l.oWrData, bus_l.oBusy, bus_l.oDone, bus_l.oPlaced});
    end
    repeat (3) begin
      @(negedge clk);
      if (m_en !== 1'b0) wr_in_rst++;
    end
    checks++;
    if (wr_in_rst !== 0) begin failures++; $display("FAIL mid_nowrite: got %0d want 0", wr_in_rst); end
    rst_n = 1'b1;
    capture(5, 1'b0);
    checks++;
    if (seq_diff() !== 0 || obs_q.size() !== 45) begin
      failures++; $display("FAIL mid_reload: got %0d writes %0d diffs want 45 0", obs_q.size(), seq_diff());
    end
    checks++;
    if (obs_done !== exp_done || m_placed !== 5'd5) begin
      failures++; $display("FAIL mid_done: got %0d placed %0d want %0d 5", obs_done, m_placed, exp_done);
    end
  endtask

  initial begin
    start_v = 1'b0; level_v = 5'd0; sel = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_level4();
    test_level0();
    test_small_full();
    test_busy_ignore();
    test_random();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
